// File: rtl/pos_cell_reader.sv
// Streams particle positions 1..count from a cell position memory onto a valid/ready port.
// Address 0 holds the particle count; a small FIFO absorbs the memory's 2-cycle read latency.
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W  = CNT_W + 1;
  localparam int NEXT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {S_IDLE, S_CNT_REQ, S_CNT_WAIT, S_STREAM, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_wait;
  logic [ADDR_WIDTH-1:0] r_particle_count;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_rden;
  logic [NEXT_W-1:0]     r_next;
  logic [CNT_W-1:0]      r_inflight;
  logic [CNT_W-1:0]      r_occ;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic                  r_vld_p0, r_vld_p1, r_vld_p2;
  logic [ADDR_WIDTH-1:0] r_tag_p0, r_tag_p1, r_tag_p2;
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_tag  [FIFO_DEPTH];

  logic                  w_cnt_latch, w_more, w_credit_ok, w_issue, w_push, w_pop;
  logic [ADDR_WIDTH-1:0] w_cnt, w_issue_addr;

  function automatic logic [ADDR_WIDTH-1:0] f_clamp_count(input logic [ADDR_WIDTH-1:0] raw);
    return (raw > MAX_CNT) ? MAX_CNT : raw;
  endfunction

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign mem_wren       = 1'b0;
  assign mem_data       = '0;
  assign mem_address    = r_mem_addr;
  assign mem_rden       = r_mem_rden;
  assign particle_count = r_particle_count;
  assign out_valid      = (r_occ != '0);
  assign out_data       = out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign out_index      = out_valid ? r_fifo_tag[r_rd_ptr] : '0;

  // The read decision is made one cycle ahead because mem_rden is registered; a pop in the
  // same cycle already frees its credit, so a full pipeline sustains one word per cycle.
  always_comb begin
    w_cnt        = f_clamp_count(mem_q[ADDR_WIDTH-1:0]);
    w_cnt_latch  = (r_state == S_CNT_WAIT) && r_wait;
    w_pop        = out_valid && out_ready;
    w_push       = r_vld_p2;
    w_more       = (r_next <= {1'b0, r_particle_count});
    w_credit_ok  = ({1'b0, r_inflight} + {1'b0, r_occ}) <
                   (SUM_W'(FIFO_DEPTH) + SUM_W'(w_pop));
    w_issue      = ((r_state == S_STREAM) && w_more && w_credit_ok) ||
                   (w_cnt_latch && (w_cnt != '0));
    w_issue_addr = (r_state == S_STREAM) ? r_next[ADDR_WIDTH-1:0] : ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = S_CNT_REQ;
      S_CNT_REQ:  w_state_nxt = S_CNT_WAIT;
      S_CNT_WAIT: if (r_wait) w_state_nxt = (w_cnt == '0) ? S_DONE : S_STREAM;
      S_STREAM:   if (!w_more && (r_inflight == '0) &&
                      ((r_occ == '0) || ((r_occ == CNT_W'(1)) && w_pop)))
                    w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait           <= 1'b0;
      r_particle_count <= '0;
      r_mem_addr       <= '0;
      r_mem_rden       <= 1'b0;
      r_next           <= '0;
      r_inflight       <= '0;
      r_occ            <= '0;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_vld_p0         <= 1'b0;
      r_vld_p1         <= 1'b0;
      r_vld_p2         <= 1'b0;
    end else begin
      r_wait     <= (r_state == S_CNT_WAIT) && !r_wait;
      r_mem_rden <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        r_mem_addr <= '0;
        r_mem_rden <= 1'b1;
      end else if (w_issue) begin
        r_mem_addr <= w_issue_addr;
        r_mem_rden <= 1'b1;
      end
      if (w_cnt_latch) begin
        r_particle_count <= w_cnt;
        r_next           <= (w_cnt != '0) ? NEXT_W'(2) : NEXT_W'(1);
      end else if (w_issue) begin
        r_next <= r_next + NEXT_W'(1);
      end
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CNT_W'(1);
        2'b01:   r_occ <= r_occ - CNT_W'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      r_vld_p0 <= w_issue;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // p0: read on the memory bus, p1: memory latency, p2: mem_q valid and written to the FIFO
  always_ff @(posedge clk) begin
    if (w_issue) r_tag_p0 <= w_issue_addr;
    r_tag_p1 <= r_tag_p0;
    r_tag_p2 <= r_tag_p1;
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= mem_q;
      r_fifo_tag[r_wr_ptr]  <= r_tag_p2;
    end
  end

endmodule

// File: tb/tb_pos_cell_reader.sv
// Bench for pos_cell_reader: a 2-cycle-latency memory model, a queue-based expected stream
// per run, table-driven runs plus reset-in-flight and backpressure sequences.
module tb_pos_cell_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mem_rden, mem_wren, out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  particle_count, mem_address, out_index;
  logic [95:0] mem_data, out_data;
  logic [95:0] mem_q = '0;
  logic [95:0] q_p1 = '0;
  logic [95:0] words [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  pos_cell_reader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .mem_address(mem_address),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Memory with a fixed 2-cycle read latency; garbage on the bus when no read is returning.
  always @(posedge clk) begin
    q_p1  <= mem_rden ? words[mem_address] : {$urandom, $urandom, $urandom};
    mem_q <= q_p1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_words(input int unsigned cnt_field);
    logic [7:0] lo;
    lo = cnt_field[7:0];
    words[0] = {$urandom, $urandom, 24'($urandom), lo};
    for (int i = 1; i < 256; i++) words[i] = {$urandom, $urandom, $urandom};
  endtask

  // mode 0: out_ready=1, mode 1: random 50%, mode 2: out_ready=0 until cycle 24
  task automatic run_cell(input int unsigned cnt_field, input int mode,
                          input int unsigned exp_cnt, input bit busy_start);
    logic [95:0] exp_d[$];
    int          exp_i[$];
    int reads, hs, dones, done_cyc, maxaddr, max_out, first_hs, hs4;
    bit finished, r;
    fill_words(cnt_field);
    for (int i = 1; i <= int'(exp_cnt); i++) begin
      exp_d.push_back(words[i]);
      exp_i.push_back(i);
    end
    reads = 0; hs = 0; dones = 0; done_cyc = -1; maxaddr = 0; max_out = 0;
    first_hs = -1; hs4 = -1; finished = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 3000 && !finished; k++) begin
      @(negedge clk);
      start = busy_start && (k == 5);
      if (done_cyc >= 0) begin
        chk("idle_after_done", {busy, done}, 2'b00);
        finished = 1;
      end else begin
        if (k == 1) chk("cnt_req", {mem_rden, mem_address}, {1'b1, 8'h00});
        else if (mem_rden) begin
          reads++;
          if (int'(mem_address) > maxaddr) maxaddr = int'(mem_address);
        end
        if (reads - hs > max_out) max_out = reads - hs;
        if (done) begin dones++; done_cyc = k; end
        if (mode == 2 && k == 24) begin
          chk("bp_reads", reads, 4);
          chk("bp_head", {out_valid, out_index, out_data}, {1'b1, 8'd1, exp_d[0]});
        end
        r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : (k >= 24);
        out_ready = r;
        if (out_valid && r) begin
          hs++;
          if (hs == 1) first_hs = k;
          if (hs == 4) hs4 = k;
          if (exp_d.size() == 0) chk("extra_word", out_index, 8'd0);
          else begin
            chk("stream_word", {out_index, out_data},
                {8'(exp_i.pop_front()), exp_d.pop_front()});
          end
        end
      end
    end
    if (!finished) chk("timeout", 0, 1);
    chk("particle_count", particle_count, 8'(exp_cnt));
    chk("word_total", hs, exp_cnt);
    chk("read_total", reads, exp_cnt);
    chk("max_address", maxaddr, exp_cnt);
    chk("done_pulses", dones, 1);
    chk("credit_bound", max_out <= 4, 1'b1);
    if (mode == 0) begin
      chk("done_cycle", done_cyc, (exp_cnt == 0) ? 4 : 7 + exp_cnt);
      if (exp_cnt > 0) chk("first_valid_cycle", first_hs, 7);
    end
    if (mode == 2) begin
      chk("bp_release", first_hs, 24);
      chk("bp_burst", hs4, first_hs + 3);
    end
  endtask

  typedef struct {
    int unsigned cnt_field;
    int          mode;
    int unsigned exp_cnt;
    bit          busy_start;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{3,   0, 3,   1'b0};
    vecs[1] = '{0,   0, 0,   1'b0};
    vecs[2] = '{219, 1, 219, 1'b0};
    vecs[3] = '{250, 0, 219, 1'b0};
    vecs[4] = '{1,   0, 1,   1'b0};
    vecs[5] = '{10,  2, 10,  1'b0};
    vecs[6] = '{255, 1, 219, 1'b0};
    vecs[7] = '{7,   0, 7,   1'b1};
    fill_words(0);

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, mem_rden, out_valid}, 4'b0000);
    chk("reset_data", {particle_count, mem_address, out_index, out_data}, 120'd0);
    chk("mem_write_tie", {mem_wren, mem_data}, 97'd0);
    rst = 1'b1;

    for (int v = 0; v < 8; v++)
      run_cell(vecs[v].cnt_field, vecs[v].mode, vecs[v].exp_cnt, vecs[v].busy_start);

    // Reset while two particle reads are in flight, then a fresh run with a start while busy.
    fill_words(12);
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", {busy, particle_count}, {1'b1, 8'd12});
    rst = 1'b0;
    #1;
    chk("async_reset_ctrl", {busy, done, mem_rden, out_valid}, 4'b0000);
    chk("async_reset_data", {particle_count, mem_address, out_index, out_data}, 120'd0);
    @(negedge clk);
    rst = 1'b1;
    run_cell(9, 0, 9, 1'b1);
    run_cell(20, 1, 20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
